// File: rtl/attn_pkg.sv
// rtl/attn_pkg.sv - shared constants, types and helpers for the attention output writeback
package attn_pkg;

    localparam int ATTN_ROWS    = 4;
    localparam int ATTN_GROUPS  = 32;
    localparam int ATTN_ENTRIES = 128;
    localparam int FP32_W       = 32;
    localparam int LANE_CNT     = 4;
    localparam int BEAT_W       = FP32_W * LANE_CNT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wb_state_t;

    // One buffered beat; {row, group} forms the SRAM address.
    typedef struct packed {
        logic [1:0]        row;
        logic [4:0]        group;
        logic [BEAT_W-1:0] data;
    } wb_beat_t;

    localparam int WB_BEAT_W = $bits(wb_beat_t);

    // Quiet or signalling NaN: all-ones exponent with a non-zero mantissa.
    function automatic logic fp32_is_nan(input logic [FP32_W-1:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/attn_wb_fifo.sv
// rtl/attn_wb_fifo.sv - synchronous beat FIFO with registered full/empty flags
module attn_wb_fifo
    import attn_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 push,
    input  logic [WB_BEAT_W-1:0] push_data,
    input  logic                 pop,
    output logic [WB_BEAT_W-1:0] pop_data,
    output logic                 full,
    output logic                 empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;
    localparam logic [PTR_W:0]   CNT_FULL = FIFO_DEPTH[PTR_W:0];

    logic [WB_BEAT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       count;
    logic [PTR_W:0]       count_nxt;
    logic                 do_push;
    logic                 do_pop;

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Occupancy after this cycle's push/pop, used to precompute the flags.
    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CNT_ONE;
        end else if (!do_push && do_pop) begin
            count_nxt = count - CNT_ONE;
        end
    end

    // Pointers, occupancy and registered flags; clr flushes the contents.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CNT_FULL);
        end
    end

    // Beat storage; no reset needed since the flags gate every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/attn_out_writeback.sv
// rtl/attn_out_writeback.sv - buffers attention output beats into the shared output SRAM (optional ATTN_WB_NAN_CHECK_EN)
module attn_out_writeback
    import attn_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [1:0]        in_row,
    input  logic [4:0]        in_group,
    input  logic [127:0]      in_data,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_gnt,
    output logic              O_mem_en,
    output logic              O_mem_we,
    output logic [ADDR_W-1:0] O_mem_addr,
    output logic [127:0]      O_mem_din,
    output logic              busy,
    output logic              done,
    output logic [7:0]        wr_count,
    output logic              overflow,
    output logic              dup_err
`ifdef ATTN_WB_NAN_CHECK_EN
    ,
    output logic              nan_flag
`endif
);

    localparam logic [7:0] ENTRY_CNT = 8'(ATTN_ENTRIES);

    wb_state_t            state;
    wb_state_t            state_nxt;
    logic                 start_q;
    logic                 start_rise;
    logic                 active;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [WB_BEAT_W-1:0] push_rec;
    logic [WB_BEAT_W-1:0] head_rec;
    wb_beat_t             head;
    logic [ADDR_W-1:0]    wr_addr;
    logic [ATTN_ENTRIES-1:0] seen;
    logic                 busy_d;
    logic                 done_d;

    assign start_rise = start && !start_q;
    assign active     = (state == ARMED) || (state == DRAIN);
    // A start edge flushes the FIFO, so nothing enters or leaves it that cycle.
    assign fifo_push  = active && in_valid && !start_rise;
    // The host owns the SRAM port whenever it asks; the FIFO simply stalls.
    assign fifo_pop   = active && !fifo_empty && !host_req && !start_rise;
    assign push_rec   = {in_row, in_group, in_data};
    assign head       = wb_beat_t'(head_rec);
    assign wr_addr    = ADDR_W'({head.row, head.group});

    attn_wb_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_rise),
        .push      (fifo_push),
        .push_data (push_rec),
        .pop       (fifo_pop),
        .pop_data  (head_rec),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a start edge (re)arms from anywhere; the pass ends once all
    // entries are covered and nothing is buffered or arriving.
    always_comb begin
        state_nxt = state;
        if (start_rise) begin
            state_nxt = ARMED;
        end else begin
            case (state)
                IDLE:  state_nxt = IDLE;
                ARMED: begin
                    if (wr_count == ENTRY_CNT) begin
                        state_nxt = (fifo_empty && !in_valid) ? DONE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty && !in_valid) begin
                        state_nxt = DONE;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Status outputs follow the state being entered so they register alongside it.
    always_comb begin
        busy_d = (state_nxt == ARMED) || (state_nxt == DRAIN);
        done_d = (state_nxt == DONE);
    end

    // Registered SRAM port, status, coverage bitmap and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q    <= 1'b0;
            host_gnt   <= 1'b0;
            O_mem_en   <= 1'b0;
            O_mem_we   <= 1'b0;
            O_mem_addr <= '0;
            O_mem_din  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_count   <= '0;
            overflow   <= 1'b0;
            dup_err    <= 1'b0;
            seen       <= '0;
        end else begin
            start_q  <= start;
            busy     <= busy_d;
            done     <= done_d;
            host_gnt <= host_req;
            O_mem_en <= host_req || fifo_pop;
            O_mem_we <= fifo_pop;
            if (host_req) begin
                O_mem_addr <= host_addr;
            end else if (fifo_pop) begin
                O_mem_addr <= wr_addr;
                O_mem_din  <= head.data;
            end
            if (start_rise) begin
                seen     <= '0;
                wr_count <= '0;
                overflow <= 1'b0;
                dup_err  <= 1'b0;
            end else begin
                if (fifo_push && fifo_full && !fifo_pop) begin
                    overflow <= 1'b1;
                end
                if (fifo_pop) begin
                    if (seen[wr_addr]) begin
                        dup_err <= 1'b1;
                    end else begin
                        seen[wr_addr] <= 1'b1;
                        wr_count      <= wr_count + 8'd1;
                    end
                end
            end
        end
    end

`ifdef ATTN_WB_NAN_CHECK_EN
    logic head_has_nan;

    // Any NaN lane in the beat being written.
    always_comb begin
        head_has_nan = 1'b0;
        for (int i = 0; i < LANE_CNT; i++) begin
            head_has_nan = head_has_nan | fp32_is_nan(head.data[i*FP32_W +: FP32_W]);
        end
    end

    // Sticky NaN indication, cleared by reset or a new pass.
    always_ff @(posedge clk) begin
        if (rst || start_rise) begin
            nan_flag <= 1'b0;
        end else if (fifo_pop && head_has_nan) begin
            nan_flag <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_attn_out_writeback.sv
// tb/tb_attn_out_writeback.sv - randomized self-checking bench for attn_out_writeback
module tb_attn_out_writeback;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         in_valid;
    logic [1:0]   in_row;
    logic [4:0]   in_group;
    logic [127:0] in_data;
    logic         host_req;
    logic [6:0]   host_addr;
    logic         host_gnt;
    logic         O_mem_en;
    logic         O_mem_we;
    logic [6:0]   O_mem_addr;
    logic [127:0] O_mem_din;
    logic         busy;
    logic         done;
    logic [7:0]   wr_count;
    logic         overflow;
    logic         dup_err;
`ifdef ATTN_WB_NAN_CHECK_EN
    logic         nan_flag;
`endif

    attn_out_writeback #(
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_row     (in_row),
        .in_group   (in_group),
        .in_data    (in_data),
        .host_req   (host_req),
        .host_addr  (host_addr),
        .host_gnt   (host_gnt),
        .O_mem_en   (O_mem_en),
        .O_mem_we   (O_mem_we),
        .O_mem_addr (O_mem_addr),
        .O_mem_din  (O_mem_din),
        .busy       (busy),
        .done       (done),
        .wr_count   (wr_count),
        .overflow   (overflow),
        .dup_err    (dup_err)
`ifdef ATTN_WB_NAN_CHECK_EN
        ,
        .nan_flag   (nan_flag)
`endif
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // SRAM image as written by the DUT, plus event counters.
    bit [127:0] sram [128];
    int wr_seen   = 0;
    int done_seen = 0;
    int gnt_seen  = 0;

    always @(negedge clk) begin
        if (O_mem_en && O_mem_we) begin
            sram[O_mem_addr] <= O_mem_din;
            wr_seen <= wr_seen + 1;
        end
        if (done) done_seen <= done_seen + 1;
        if (host_gnt) gnt_seen <= gnt_seen + 1;
    end

    // Reference model: a queue of pending beats, coverage set and expected SRAM contents.
    typedef struct packed {
        logic [6:0]   a;
        logic [127:0] d;
    } mbeat_t;

    mbeat_t     mq [$];
    bit [127:0] exp_mem [128];
    bit [127:0] m_seen;
    bit         m_active;
    bit         m_start_q;
    bit         m_ovf;
    bit         m_dup;
    int         m_cnt;

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < 128; i++) begin
            if (sram[i] !== exp_mem[i]) n++;
        end
        return n;
    endfunction

    function automatic logic [127:0] rand128();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r;
    endfunction

    // Drive one cycle of inputs and advance the model by that cycle.
    task automatic step(input logic v, input logic [6:0] a, input logic [127:0] d,
                        input logic hq, input logic [6:0] ha, input logic st, input logic rs);
        mbeat_t b;
        mbeat_t nb;
        bit pop;
        bit full;
        bit endp;
        bit rise;
        @(negedge clk);
        in_valid  = v;
        in_row    = a[6:5];
        in_group  = a[4:0];
        in_data   = d;
        host_req  = hq;
        host_addr = ha;
        start     = st;
        rst       = rs;
        if (rs) begin
            mq.delete();
            m_active = 0; m_start_q = 0; m_cnt = 0; m_seen = '0; m_ovf = 0; m_dup = 0;
        end else begin
            rise = st && !m_start_q;
            m_start_q = st;
            if (rise) begin
                mq.delete();
                m_active = 1; m_cnt = 0; m_seen = '0; m_ovf = 0; m_dup = 0;
            end else if (m_active) begin
                full = (mq.size() == DEPTH);
                pop  = (mq.size() != 0) && !hq;
                endp = (m_cnt == 128) && (mq.size() == 0) && !v;
                if (pop) begin
                    b = mq.pop_front();
                    exp_mem[b.a] = b.d;
                    if (m_seen[b.a]) m_dup = 1;
                    else begin
                        m_seen[b.a] = 1;
                        m_cnt++;
                    end
                end
                if (v) begin
                    if (full && !pop) m_ovf = 1;
                    else begin
                        nb.a = a;
                        nb.d = d;
                        mq.push_back(nb);
                    end
                end
                if (endp) m_active = 0;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 7'd0, 128'd0, 1'b0, 7'd0, 1'b0, 1'b0);
    endtask

    task automatic do_start();
        step(1'b0, 7'd0, 128'd0, 1'b0, 7'd0, 1'b1, 1'b0);
    endtask

    task automatic beat(input logic [6:0] a, input logic [127:0] d);
        step(1'b1, a, d, 1'b0, 7'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 7'd0, 128'd0, 1'b0, 7'd0, 1'b0, 1'b1);
        step(1'b0, 7'd0, 128'd0, 1'b0, 7'd0, 1'b0, 1'b1);
        #1;
        compared++;
        if ({host_gnt, O_mem_en, O_mem_we, busy, done, overflow, dup_err} !== 7'b0) begin
            mismatched++;
            $display("FAIL reset_flags: got %b required 0", {host_gnt, O_mem_en, O_mem_we, busy, done, overflow, dup_err});
        end
        compared++;
        if ({O_mem_addr, O_mem_din, wr_count} !== '0) begin
            mismatched++;
            $display("FAIL reset_values: addr %0h din %0h wr_count %0d required 0", O_mem_addr, O_mem_din, wr_count);
        end
        idle(2);
        #1;
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_idle_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_full_pass();
        int d0 = done_seen;
        logic [127:0] d;
        do_start();
        #1;
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL armed_busy: got %b required 1", busy);
        end
        for (int i = 0; i < 128; i++) begin
            d = {4{25'd0, 7'(i)}};
            beat(7'(i), d);
            #1;
            if (i == 0) begin
                compared++;
                if (O_mem_en !== 1'b0) begin
                    mismatched++;
                    $display("FAIL latency_early: en %b required 0 one cycle after first beat", O_mem_en);
                end
            end
            if (i == 1) begin
                compared++;
                if ({O_mem_en, O_mem_we, O_mem_addr, O_mem_din} !== {1'b1, 1'b1, 7'd0, 128'd0}) begin
                    mismatched++;
                    $display("FAIL latency_first_write: en %b we %b addr %0h required 1 1 0", O_mem_en, O_mem_we, O_mem_addr);
                end
            end
        end
        idle(1);
        #1;
        compared++;
        if (done !== 1'b0) begin
            mismatched++;
            $display("FAIL done_early: got %b required 0", done);
        end
        idle(1);
        #1;
        compared++;
        if (done !== 1'b1) begin
            mismatched++;
            $display("FAIL done_timing: got %b required 1 three cycles after last beat", done);
        end
        idle(4);
        compared++;
        if (wr_count !== 8'd128) begin
            mismatched++;
            $display("FAIL full_wr_count: got %0d required 128", wr_count);
        end
        compared++;
        if (done_seen - d0 !== 1) begin
            mismatched++;
            $display("FAIL full_done_pulses: got %0d required 1", done_seen - d0);
        end
        compared++;
        if (mem_diffs() !== 0) begin
            mismatched++;
            $display("FAIL full_sram: %0d entries differ, required 0", mem_diffs());
        end
        compared++;
        if ({busy, overflow, dup_err} !== 3'b000) begin
            mismatched++;
            $display("FAIL full_status: busy/ovf/dup %b required 000", {busy, overflow, dup_err});
        end
    endtask

    task automatic test_host_contention();
        int d0 = done_seen;
        int g0 = gnt_seen;
        do_start();
        for (int i = 0; i < 128; i++) begin
            step(1'b1, 7'(i), rand128(), (i >= 40 && i < 46), 7'($urandom_range(0, 127)), 1'b0, 1'b0);
        end
        idle(10);
        compared++;
        if (gnt_seen - g0 !== 6) begin
            mismatched++;
            $display("FAIL host_gnt_cycles: got %0d required 6", gnt_seen - g0);
        end
        compared++;
        if (overflow !== 1'b1 || m_ovf !== 1'b1) begin
            mismatched++;
            $display("FAIL contention_overflow: got %b required 1", overflow);
        end
        compared++;
        if (int'(wr_count) !== m_cnt || wr_count >= 8'd128) begin
            mismatched++;
            $display("FAIL contention_wr_count: got %0d required %0d (<128)", wr_count, m_cnt);
        end
        compared++;
        if (done_seen - d0 !== 0) begin
            mismatched++;
            $display("FAIL contention_no_done: got %0d pulses required 0", done_seen - d0);
        end
        compared++;
        if (mem_diffs() !== 0) begin
            mismatched++;
            $display("FAIL contention_sram: %0d entries differ, required 0", mem_diffs());
        end
    endtask

    task automatic test_duplicate();
        int d0 = done_seen;
        logic [127:0] second;
        second = rand128();
        do_start();
        for (int i = 0; i < 128; i++) begin
            beat(7'(i), rand128());
            if (i == 'h45) beat(7'h45, second);
        end
        idle(6);
        compared++;
        if (dup_err !== 1'b1) begin
            mismatched++;
            $display("FAIL dup_err: got %b required 1", dup_err);
        end
        compared++;
        if (wr_count !== 8'd128) begin
            mismatched++;
            $display("FAIL dup_wr_count: got %0d required 128", wr_count);
        end
        compared++;
        if (sram[7'h45] !== second) begin
            mismatched++;
            $display("FAIL dup_last_wins: got %0h required %0h", sram[7'h45], second);
        end
        compared++;
        if (done_seen - d0 !== 1 || mem_diffs() !== 0) begin
            mismatched++;
            $display("FAIL dup_pass: done %0d diffs %0d required 1 and 0", done_seen - d0, mem_diffs());
        end
    endtask

    task automatic test_full_push_pop();
        int g0 = gnt_seen;
        do_start();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 7'(8 + i), rand128(), (i < 4), 7'(i), 1'b0, 1'b0);
        end
        idle(8);
        compared++;
        if (overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL pushpop_overflow: got %b required 0", overflow);
        end
        compared++;
        if (wr_count !== 8'd10 || gnt_seen - g0 !== 4) begin
            mismatched++;
            $display("FAIL pushpop_count: wr_count %0d gnt %0d required 10 and 4", wr_count, gnt_seen - g0);
        end
        compared++;
        if (mem_diffs() !== 0) begin
            mismatched++;
            $display("FAIL pushpop_sram: %0d entries differ, required 0", mem_diffs());
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        do_start();
        for (int i = 0; i < 50; i++) beat(7'(i), rand128());
        step(1'b0, 7'd0, 128'd0, 1'b0, 7'd0, 1'b0, 1'b1);
        #1;
        compared++;
        if ({host_gnt, O_mem_en, O_mem_we, busy, done, overflow, dup_err, wr_count, O_mem_addr, O_mem_din} !== '0) begin
            mismatched++;
            $display("FAIL reset_mid_outputs: en %b busy %b wr_count %0d required all 0", O_mem_en, busy, wr_count);
        end
        idle(1);
        d0 = done_seen;
        do_start();
        for (int i = 0; i < 128; i++) beat(7'(127 - i), rand128());
        idle(6);
        compared++;
        if (wr_count !== 8'd128 || done_seen - d0 !== 1) begin
            mismatched++;
            $display("FAIL reset_mid_repass: wr_count %0d done %0d required 128 and 1", wr_count, done_seen - d0);
        end
        compared++;
        if (mem_diffs() !== 0) begin
            mismatched++;
            $display("FAIL reset_mid_sram: %0d entries differ, required 0", mem_diffs());
        end
    endtask

    task automatic test_rearm();
        int d0 = done_seen;
        do_start();
        for (int i = 0; i < 20; i++) beat(7'(i), rand128());
        do_start();
        #1;
        compared++;
        if (wr_count !== 8'd0) begin
            mismatched++;
            $display("FAIL rearm_wr_count: got %0d required 0", wr_count);
        end
        for (int i = 0; i < 128; i++) beat(7'(i), rand128());
        idle(6);
        compared++;
        if (wr_count !== 8'd128 || done_seen - d0 !== 1 || mem_diffs() !== 0) begin
            mismatched++;
            $display("FAIL rearm_pass: wr_count %0d done %0d diffs %0d required 128 1 0", wr_count, done_seen - d0, mem_diffs());
        end
    endtask

`ifdef ATTN_WB_NAN_CHECK_EN
    task automatic test_nan();
        logic [127:0] d;
        d = {32'h7FC00000, 32'h3F800000, 32'h40000000, 32'h00000000};
        do_start();
        #1;
        compared++;
        if (nan_flag !== 1'b0) begin
            mismatched++;
            $display("FAIL nan_cleared: got %b required 0", nan_flag);
        end
        beat(7'd3, d);
        idle(4);
        compared++;
        if (nan_flag !== 1'b1) begin
            mismatched++;
            $display("FAIL nan_flag: got %b required 1", nan_flag);
        end
        compared++;
        if (sram[3] !== d) begin
            mismatched++;
            $display("FAIL nan_data: got %0h required %0h", sram[3], d);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_row = '0; in_group = '0;
        in_data = '0; host_req = 1'b0; host_addr = '0;
        test_reset();
        test_full_pass();
        test_host_contention();
        test_duplicate();
        test_full_push_pop();
        test_reset_mid();
        test_rearm();
`ifdef ATTN_WB_NAN_CHECK_EN
        test_nan();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
